// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default width.
// No latency or backpressure of its own.
// Imported by restoring_divider and div_step.
package div_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring iteration: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
// Combinational, zero latency.
// No flow control; the caller decides when to register the result.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] quo_nxt
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem < dvs always holds, so the shifted value fits in WIDTH+1 bits and diff[WIDTH] is the borrow.
   assign shifted = {rem, quo[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs};

   always_comb begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
         rem_nxt = diff[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider; signed truncating mode compiled in with DIV_SIGNED_EN.
// Latency: Done WIDTH+1 edges after Start is accepted, 1 edge for a zero divisor.
// Backpressure: Start is accepted only in IDLE; requests while Busy/Done are dropped.
module restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic             Signed,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic             zero_pend;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic             accept;

   assign accept = (state == IDLE) && Start;

`ifdef DIV_SIGNED_EN
   logic a_neg;
   logic b_neg;
   logic neg_quo;
   logic neg_rem;

   assign a_neg = Signed & Dividend[WIDTH-1];
   assign b_neg = Signed & Divisor[WIDTH-1];
   assign a_mag = a_neg ? -Dividend : Dividend;
   assign b_mag = b_neg ? -Divisor : Divisor;

   always_ff @(posedge CLK) begin
      if (RST) begin
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
      end else if (accept) begin
         neg_quo <= a_neg ^ b_neg;
         neg_rem <= a_neg;
      end
   end

   // Most-negative / -1 falls out naturally: magnitude 2^(W-1) negated wraps to itself.
   assign q_fin = neg_quo ? -quo_q : quo_q;
   assign r_fin = neg_rem ? -rem_q : rem_q;
`else
   logic unused_signed;

   assign unused_signed = Signed;
   assign a_mag         = Dividend;
   assign b_mag         = Divisor;
   assign q_fin         = quo_q;
   assign r_fin         = rem_q;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .dvs     (dvs_q),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         zero_pend <= 1'b0;
         DivZero   <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  state     <= CALC;
                  cnt       <= '0;
                  rem_q     <= '0;
                  dvs_q     <= b_mag;
                  zero_pend <= (Divisor == '0);
                  DivZero   <= 1'b0;
                  // A zero divisor keeps the raw dividend so it can be returned as the remainder.
                  quo_q     <= (Divisor == '0) ? Dividend : a_mag;
               end
            end
            CALC: begin
               if (zero_pend) begin
                  state     <= DONE;
                  DivZero   <= 1'b1;
                  Quotient  <= '1;
                  Remainder <= quo_q;
               end else if (cnt == CNT_W'(WIDTH)) begin
                  state     <= DONE;
                  Quotient  <= q_fin;
                  Remainder <= r_fin;
               end else begin
                  rem_q <= rem_nxt;
                  quo_q <= quo_nxt;
                  cnt   <= cnt + CNT_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign Busy = (state == CALC);
   assign Done = (state == DONE);

   wire unused_accept = accept;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: transaction-level model checked every cycle
// plus literal expectations for the documented corner cases.
module tb_restoring_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         sgn = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic         divzero;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;

   int checks = 0;
   int passed = 0;

   restoring_divider #(.WIDTH(W)) dut (
      .CLK       (clk),
      .RST       (rst),
      .Start     (start),
      .Signed    (sgn),
      .Dividend  (dividend),
      .Divisor   (divisor),
      .Busy      (busy),
      .Done      (done),
      .DivZero   (divzero),
      .Quotient  (quotient),
      .Remainder (remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   // Reference arithmetic: plain division, 64-bit signed to sidestep overflow.
   task automatic ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
      longint sa;
      longint sb;
      dz = (b == '0);
      if (b == '0) begin
         q = '1;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
`ifdef DIV_SIGNED_EN
         if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
         end
`endif
      end
      if (s === 1'bx) q = 'x;
   endtask

   // Transaction-level model: tracks outstanding request and cycles remaining.
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic         m_dz = 1'b0;
   logic [W-1:0] m_q = '0;
   logic [W-1:0] m_r = '0;
   logic [W-1:0] n_q;
   logic [W-1:0] n_r;
   logic         n_dz;
   bit           pending = 1'b0;
   int           remaining = 0;
   bit           chk_en = 1'b0;

   always @(posedge clk) begin
      logic prev_done;
      prev_done = m_done;
      if (rst) begin
         pending = 0;
         m_done  = 0;
         m_busy  = 0;
         m_dz    = 0;
         m_q     = '0;
         m_r     = '0;
      end else begin
         m_done = 0;
         if (pending) begin
            remaining--;
            if (remaining == 0) begin
               pending = 0;
               m_done  = 1;
               m_q     = n_q;
               m_r     = n_r;
               m_dz    = n_dz;
            end
         end else if (!prev_done && start) begin
            ref_div(sgn, dividend, divisor, n_q, n_r, n_dz);
            remaining = (divisor == '0) ? 1 : W + 1;
            pending   = 1;
            m_dz      = 0;
         end
         m_busy = pending;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", W'(busy), W'(m_busy));
         check("done", W'(done), W'(m_done));
         check("divzero", W'(divzero), W'(m_dz));
         check("quotient", quotient, m_q);
         check("remainder", remainder, m_r);
      end
   end

   task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
      @(posedge clk); #2;
      start = 1'b1; sgn = s; dividend = a; divisor = b;
      @(posedge clk); #2;
      start = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!done && lat < 100);
      check("done_within_bound", W'(done), W'(1));
      q  = quotient;
      r  = remainder;
      dz = divzero;
   endtask

   initial begin
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
      int           done_cnt;
      logic [W-1:0] a;
      logic [W-1:0] b;

      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      check("reset_q", quotient, '0);
      check("reset_r", remainder, '0);
      check("reset_busy", W'(busy), '0);

      do_div(1'b0, 32'd100, 32'd7, q, r, dz, lat);
      check("100/7 q", q, 32'd14);
      check("100/7 r", r, 32'd2);
      check("100/7 dz", W'(dz), '0);
      check("100/7 latency", W'(lat), 32'd33);

      do_div(1'b0, 32'hFFFF_FFFF, 32'd1, q, r, dz, lat);
      check("max/1 q", q, 32'hFFFF_FFFF);
      check("max/1 r", r, 32'd0);

      do_div(1'b0, 32'd5, 32'd9, q, r, dz, lat);
      check("5/9 q", q, 32'd0);
      check("5/9 r", r, 32'd5);

      do_div(1'b0, 32'd1234, 32'd0, q, r, dz, lat);
      check("1234/0 latency", W'(lat), 32'd1);
      check("1234/0 dz", W'(dz), 32'd1);
      check("1234/0 q", q, 32'hFFFF_FFFF);
      check("1234/0 r", r, 32'd1234);

`ifdef DIV_SIGNED_EN
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, dz, lat);
      check("-7/2 q", q, 32'hFFFF_FFFD);
      check("-7/2 r", r, 32'hFFFF_FFFF);
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, lat);
      check("minneg/-1 q", q, 32'h8000_0000);
      check("minneg/-1 r", r, 32'd0);
`else
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, dz, lat);
      check("signed-ignored q", q, 32'h7FFF_FFFC);
      check("signed-ignored r", r, 32'd1);
`endif

      // A second request mid-calculation must be dropped.
      @(posedge clk); #2;
      start = 1'b1; sgn = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk); #2 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 start = 1'b1; dividend = 32'd20; divisor = 32'd3;
      @(posedge clk); #2 start = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!done && lat < 100);
      check("ignored_start q", quotient, 32'd14);
      check("ignored_start r", remainder, 32'd2);

      // Reset at iteration 10 aborts with no Done pulse.
      @(posedge clk); #2;
      start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk); #2 start = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      check("abort_no_done", W'(done_cnt), '0);
      check("abort_q", quotient, '0);
      check("abort_r", remainder, '0);
      check("abort_busy", W'(busy), '0);

      do_div(1'b0, 32'd20, 32'd3, q, r, dz, lat);
      check("20/3 q", q, 32'd6);
      check("20/3 r", r, 32'd2);

      for (int n = 0; n < 250; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 15));
            2:       b = $urandom;
            default: b = a >> $urandom_range(0, 31);
         endcase
         if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
         do_div(1'($urandom_range(0, 1)), a, b, q, r, dz, lat);
      end

      repeat (3) @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >=4).
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port Start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port Signed  input  1  1 = two's-complement operands; sampled with Start.
REQ-006 SHALL have port Dividend  input  WIDTH  numerator; sampled with Start.
REQ-007 SHALL have port Divisor  input  WIDTH  denominator; sampled with Start.
REQ-008 SHALL have port Busy  output  1  high from the cycle after Start acceptance until Done.
REQ-009 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port DivZero  output  1  divisor was zero; valid with Done, held until next Start.
REQ-011 SHALL have port Quotient  output  WIDTH  result, held until next accepted Start.
REQ-012 SHALL have port Remainder  output  WIDTH  result, held until next accepted Start.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on Start; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-014 SHALL perform one restoring step per CALC cycle: shift {rem,quo} left 1, compare rem >= divisor magnitude, subtract and set quo LSB = 1 if so, else restore and set quo LSB = 0.
REQ-015 SHALL use an internal iteration counter of $clog2(WIDTH)+1 bits, cleared on Start acceptance.
REQ-016 SHALL assert Done exactly WIDTH+1 rising edges after the edge sampling Start, for exactly one cycle; Busy low in that cycle.
REQ-017 SHALL ignore Start while Busy or Done is high (no restart, no corruption).
REQ-018 SHALL, for Divisor = 0, skip CALC: Done one edge after acceptance, DivZero = 1, Quotient = all ones, Remainder = Dividend.
REQ-019 SHALL produce unsigned results where Dividend = Quotient*Divisor + Remainder, Remainder < Divisor.
REQ-020 SHALL update Quotient/Remainder only on the CALC->DONE (or divide-by-zero) transition.

Reset
REQ-021 SHALL, on RST high at a rising edge, enter IDLE and clear Busy, Done, DivZero, Quotient, Remainder, counter and internal registers to 0.
REQ-022 SHALL abort any in-progress division on reset with no Done pulse; RST dominates a simultaneous Start.

Configuration
REQ-023 SHALL recognise macro DIV_SIGNED_EN.
REQ-024 SHALL, with DIV_SIGNED_EN defined, honour Signed: divide magnitudes, quotient negative iff operand signs differ, remainder takes dividend's sign (truncating division); most-negative / -1 yields Quotient = most-negative, Remainder = 0.
REQ-025 SHALL, without DIV_SIGNED_EN, ignore Signed, treat all operands as unsigned, and contain no sign-correction logic.

Structure
REQ-026 SHALL take the FSM state enum (IDLE, CALC, DONE) and the default-width constant from shared package div_pkg.
REQ-027 SHALL place the single restoring iteration (shift, magnitude compare, conditional subtract) in one sub-module div_step, instantiated once.

Verification
REQ-028 SHALL cover: WIDTH=32, unsigned 100/7 -> Done at edge 33 after Start, Quotient=14, Remainder=2, DivZero=0.
REQ-029 SHALL cover: 0xFFFFFFFF/1 unsigned -> Quotient=0xFFFFFFFF, Remainder=0; 5/9 -> Quotient=0, Remainder=5.
REQ-030 SHALL cover: 1234/0 -> Done one edge after Start, DivZero=1, Quotient=0xFFFFFFFF, Remainder=1234.
REQ-031 SHALL cover (DIV_SIGNED_EN): signed -7/2 -> Quotient=-3, Remainder=-1; 0x80000000/-1 -> Quotient=0x80000000, Remainder=0; without macro, Signed=1 with 0xFFFFFFF9/2 -> Quotient=0x7FFFFFFC, Remainder=1.
REQ-032 SHALL cover: second Start (20/3) pulsed mid-CALC of 100/7 -> ignored, results 14/2; RST at iteration 10 -> no Done, all outputs 0, next 20/3 -> 6/2.
